// File: rtl/game_sequencer_pkg.sv
// Shared game constants, dino_state encodings and FSM state encoding for the
// game sequencer and the pixel renderer.
package game_sequencer_pkg;

  localparam int unsigned COORD_W  = 12;
  localparam int unsigned Y_SUM_W  = COORD_W + 1;
  localparam int unsigned SCORE_W  = 16;
  localparam int unsigned VEL_W    = 8;
  localparam int unsigned LFSR_W   = 16;

  localparam int unsigned GROUND_Y     = 200;
  localparam int unsigned DINO_X       = 40;
  localparam int unsigned SCREEN_W     = 320;
  localparam int unsigned JUMP_V       = 12;
  localparam int unsigned GRAVITY      = 1;
  localparam int unsigned OBS_SPEED    = 3;
  localparam int unsigned HIT_DX       = 14;
  localparam int unsigned HIT_DY       = 16;
  localparam int unsigned ANIM_DIV     = 8;
  localparam int unsigned SCORE_DIV    = 6;
  localparam int unsigned NIGHT_PERIOD = 100;
  localparam int unsigned DEAD_HOLD    = 30;

  localparam int unsigned GROUND_SCREEN_Y = GROUND_Y;
  localparam int unsigned DINO_SCREEN_X   = DINO_X;
  localparam int unsigned SPAWN_X         = SCREEN_W + 32;

  localparam int unsigned ANIM_W  = $clog2(ANIM_DIV);
  localparam int unsigned SDIV_W  = $clog2(SCORE_DIV);
  localparam int unsigned NIGHT_W = $clog2(NIGHT_PERIOD);
  localparam int unsigned HOLD_W  = $clog2(DEAD_HOLD + 1);

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    DS_RUN_A = 2'd0,
    DS_RUN_B = 2'd1,
    DS_JUMP  = 2'd2,
    DS_DEAD  = 2'd3
  } dino_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_JUMP = 2'd2,
    ST_DEAD = 2'd3
  } fsm_state_e;

  // Fibonacci LFSR step, taps 16/14/13/11
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/game_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a registered
// one-cycle rising-edge pulse.
module game_sequencer_btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      meta      <= btn;
      sync      <= meta;
      sync_prev <= sync;
      rise      <= sync & ~sync_prev;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate dino game controller: jump physics, obstacle scrolling, collision,
// score and day/night. Scene outputs change only in the cycle after frame_tick.
module game_sequencer
  import game_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                jump_btn,
  output logic [COORD_W-1:0]  dino_y,
  output logic [1:0]          dino_state,
  output logic [COORD_W-1:0]  obstacle_x,
  output logic                night,
  output logic [SCORE_W-1:0]  score,
  output logic                playing
);

  fsm_state_e          state, state_d;
  logic [VEL_W-1:0]    vel, vel_d;
  logic [LFSR_W-1:0]   lfsr, lfsr_d;
  logic [ANIM_W-1:0]   anim_cnt, anim_cnt_d;
  logic [SDIV_W-1:0]   sdiv_cnt, sdiv_cnt_d;
  logic [NIGHT_W-1:0]  night_cnt, night_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
  logic                jump_req, jump_req_d;
  logic                jump_rise;

  logic [COORD_W-1:0]  dino_y_d, obstacle_x_d;
  logic [1:0]          dino_state_d;
  logic                night_d, playing_d;
  logic [SCORE_W-1:0]  score_d;

  logic                hit;
  logic                respawn;
  logic signed [Y_SUM_W-1:0] y_sum;

  game_sequencer_btn_sync_edge u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (jump_btn),
    .rise  (jump_rise)
  );

  // Collision and motion helpers, all on pre-update values
  assign hit = (obstacle_x > COORD_W'(DINO_X - HIT_DX)) &&
               (obstacle_x < COORD_W'(DINO_X + HIT_DX)) &&
               (dino_y > COORD_W'(GROUND_Y - HIT_DY));
  assign respawn = (obstacle_x <= COORD_W'(OBS_SPEED));
  assign y_sum   = $signed({1'b0, dino_y}) +
                   $signed({{(Y_SUM_W - VEL_W){vel[VEL_W-1]}}, vel});

  always_comb begin
    state_d      = state;
    vel_d        = vel;
    lfsr_d       = lfsr;
    anim_cnt_d   = anim_cnt;
    sdiv_cnt_d   = sdiv_cnt;
    night_cnt_d  = night_cnt;
    hold_cnt_d   = hold_cnt;
    dino_y_d     = dino_y;
    dino_state_d = dino_state;
    obstacle_x_d = obstacle_x;
    night_d      = night;
    score_d      = score;
    playing_d    = playing;
    // A press coinciding with frame_tick is kept for the following frame
    jump_req_d   = frame_tick ? jump_rise : (jump_req | jump_rise);

    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (jump_req) begin
            state_d      = ST_RUN;
            score_d      = '0;
            obstacle_x_d = COORD_W'(SPAWN_X);
            dino_state_d = DS_RUN_A;
            playing_d    = 1'b1;
            anim_cnt_d   = '0;
            sdiv_cnt_d   = '0;
            night_cnt_d  = '0;
          end
        end

        ST_RUN, ST_JUMP: begin
          if (hit) begin
            state_d      = ST_DEAD;
            dino_state_d = DS_DEAD;
            playing_d    = 1'b0;
            hold_cnt_d   = '0;
          end else begin
            lfsr_d       = lfsr_step(lfsr);
            obstacle_x_d = respawn ? COORD_W'(SCREEN_W) + COORD_W'(lfsr[6:0])
                                   : obstacle_x - COORD_W'(OBS_SPEED);

            if (sdiv_cnt == SDIV_W'(SCORE_DIV - 1)) begin
              sdiv_cnt_d = '0;
              if (score != '1) begin
                score_d = score + SCORE_W'(1);
                if (night_cnt == NIGHT_W'(NIGHT_PERIOD - 1)) begin
                  night_cnt_d = '0;
                  night_d     = ~night;
                end else begin
                  night_cnt_d = night_cnt + NIGHT_W'(1);
                end
              end
            end else begin
              sdiv_cnt_d = sdiv_cnt + SDIV_W'(1);
            end

            if (state == ST_RUN) begin
              if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
                anim_cnt_d   = '0;
                dino_state_d = (dino_state == DS_RUN_A) ? DS_RUN_B : DS_RUN_A;
              end else begin
                anim_cnt_d = anim_cnt + ANIM_W'(1);
              end
              if (jump_req) begin
                state_d      = ST_JUMP;
                vel_d        = VEL_W'(0) - VEL_W'(JUMP_V);
                dino_state_d = DS_JUMP;
              end
            end else begin
              vel_d = vel + VEL_W'(GRAVITY);
              if (y_sum >= $signed(Y_SUM_W'(GROUND_Y))) begin
                dino_y_d     = COORD_W'(GROUND_Y);
                vel_d        = '0;
                state_d      = ST_RUN;
                dino_state_d = DS_RUN_A;
                anim_cnt_d   = '0;
              end else if (y_sum[Y_SUM_W-1]) begin
                dino_y_d = '0;
              end else begin
                dino_y_d = y_sum[COORD_W-1:0];
              end
            end
          end
        end

        ST_DEAD: begin
          if (hold_cnt != HOLD_W'(DEAD_HOLD)) begin
            hold_cnt_d = hold_cnt + HOLD_W'(1);
          end else if (jump_req) begin
            state_d      = ST_RUN;
            dino_y_d     = COORD_W'(GROUND_Y);
            vel_d        = '0;
            obstacle_x_d = COORD_W'(SPAWN_X);
            score_d      = '0;
            night_d      = 1'b0;
            dino_state_d = DS_RUN_A;
            playing_d    = 1'b1;
            anim_cnt_d   = '0;
            sdiv_cnt_d   = '0;
            night_cnt_d  = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vel        <= '0;
      lfsr       <= LFSR_SEED;
      anim_cnt   <= '0;
      sdiv_cnt   <= '0;
      night_cnt  <= '0;
      hold_cnt   <= '0;
      jump_req   <= 1'b0;
      dino_y     <= COORD_W'(GROUND_Y);
      dino_state <= DS_RUN_A;
      obstacle_x <= COORD_W'(SPAWN_X);
      night      <= 1'b0;
      score      <= '0;
      playing    <= 1'b0;
    end else begin
      state      <= state_d;
      vel        <= vel_d;
      lfsr       <= lfsr_d;
      anim_cnt   <= anim_cnt_d;
      sdiv_cnt   <= sdiv_cnt_d;
      night_cnt  <= night_cnt_d;
      hold_cnt   <= hold_cnt_d;
      jump_req   <= jump_req_d;
      dino_y     <= dino_y_d;
      dino_state <= dino_state_d;
      obstacle_x <= obstacle_x_d;
      night      <= night_d;
      score      <= score_d;
      playing    <= playing_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: idle, run animation, jump arc, collision,
// dead hold and restart, score/night over 600 frames, async reset mid-jump.
module tb_game_sequencer;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        jump_btn;
  logic [11:0] dino_y;
  logic [1:0]  dino_state;
  logic [11:0] obstacle_x;
  logic        night;
  logic [15:0] score;
  logic        playing;

  int n_checks = 0;
  int n_errors = 0;

  game_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .jump_btn   (jump_btn),
    .dino_y     (dino_y),
    .dino_state (dino_state),
    .obstacle_x (obstacle_x),
    .night      (night),
    .score      (score),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame: tick pulse, then outputs are sampled on the following negedge
  task automatic do_frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) jump_btn = 1'b1;
    repeat (4) @(negedge clk);
    jump_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  initial begin
    int          y_exp;
    int          v_exp;
    int          obs_exp;
    int          respawns;
    logic [15:0] lfsr_m;
    logic        found;

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dino_y", dino_y, 200);
    check("rst_obstacle_x", obstacle_x, 352);
    check("rst_playing", playing, 0);
    rst_n = 1'b1;

    // Idle: nothing moves without a press
    repeat (10) do_frame();
    check("idle_dino_y", dino_y, 200);
    check("idle_obstacle_x", obstacle_x, 352);
    check("idle_playing", playing, 0);
    check("idle_score", score, 0);
    check("idle_dino_state", dino_state, 0);
    check("idle_night", night, 0);

    // Start game; entry frame reloads obstacle without moving it
    press();
    do_frame();
    check("start_playing", playing, 1);
    check("start_obstacle_x", obstacle_x, 352);
    check("start_dino_state", dino_state, 0);
    for (int k = 1; k <= 16; k++) begin
      do_frame();
      check("run_obstacle_x", obstacle_x, 32'(352 - 3 * k));
      check("run_anim", dino_state, (k >= 8 && k < 16) ? 1 : 0);
    end
    check("run_score", score, 2);

    // Jump: start frame keeps y, then the ballistic arc
    press();
    do_frame();
    check("jump_start_state", dino_state, 2);
    check("jump_start_y", dino_y, 200);
    check("jump_start_obs", obstacle_x, 301);
    y_exp = 200;
    v_exp = -12;
    for (int k = 1; k <= 25; k++) begin
      do_frame();
      y_exp = y_exp + v_exp;
      v_exp = v_exp + 1;
      if (y_exp >= 200) y_exp = 200;
      check("jump_y", dino_y, 32'(y_exp));
      check("jump_state", dino_state, (k == 25) ? 0 : 2);
    end
    check("jump_y_k1_k3_sanity", 32'(200 - 12 - 11 - 10), 167);
    check("land_obs", obstacle_x, 226);
    check("land_playing", playing, 1);

    // Obstacle walks into the grounded dino: pre-update x = 52 on frame 59
    for (int j = 1; j <= 58; j++) do_frame();
    check("pre_hit_playing", playing, 1);
    check("pre_hit_obs", obstacle_x, 52);
    do_frame();
    check("hit_state", dino_state, 3);
    check("hit_playing", playing, 0);
    check("hit_obs", obstacle_x, 52);
    check("hit_y", dino_y, 200);
    check("hit_score", score, 16);
    repeat (2) do_frame();
    check("dead_frozen_obs", obstacle_x, 52);
    check("dead_frozen_score", score, 16);
    check("dead_frozen_state", dino_state, 3);

    // Dead hold: early presses ignored, frame 31 accepts
    for (int n = 3; n <= 9; n++) do_frame();
    press();
    do_frame();
    check("dead_f10_state", dino_state, 3);
    check("dead_f10_playing", playing, 0);
    for (int n = 11; n <= 29; n++) do_frame();
    press();
    do_frame();
    check("dead_f30_state", dino_state, 3);
    press();
    do_frame();
    check("restart_playing", playing, 1);
    check("restart_state", dino_state, 0);
    check("restart_score", score, 0);
    check("restart_obs", obstacle_x, 352);
    check("restart_y", dino_y, 200);
    check("restart_night", night, 0);

    // 600 frames with jumps over every obstacle; LFSR advanced 100 times so far
    lfsr_m = 16'hACE1;
    repeat (100) lfsr_m = lfsr_adv(lfsr_m);
    obs_exp  = 352;
    respawns = 0;
    for (int f = 1; f <= 600; f++) begin
      if (dino_state < 2 && obstacle_x >= 60 && obstacle_x <= 98) press();
      do_frame();
      if (obs_exp <= 3) begin
        obs_exp = 320 + int'(lfsr_m[6:0]);
        respawns++;
        check("respawn_range", 32'(obstacle_x >= 320), 1);
      end else begin
        obs_exp = obs_exp - 3;
      end
      lfsr_m = lfsr_adv(lfsr_m);
      check("long_obs", obstacle_x, 32'(obs_exp));
      check("long_playing", playing, 1);
      if (f == 599) begin
        check("score_599", score, 99);
        check("night_599", night, 0);
      end
    end
    check("score_600", score, 100);
    check("night_600", night, 1);
    check("respawn_seen", 32'(respawns > 0), 1);

    // Find a safe moment, jump, then reset at dino_y = 150
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dino_state < 2 && obstacle_x >= 60) begin
        found = 1'b1;
        break;
      end
      do_frame();
    end
    check("safe_jump_found", 32'(found), 1);
    press();
    do_frame();
    repeat (5) do_frame();
    check("midjump_y", dino_y, 150);
    check("midjump_state", dino_state, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", dino_y, 200);
    check("async_rst_state", dino_state, 0);
    check("async_rst_obs", obstacle_x, 352);
    check("async_rst_night", night, 0);
    check("async_rst_score", score, 0);
    check("async_rst_playing", playing, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
